// File: rtl/icache_assoc.sv
// N-way set-associative read-only instruction cache with tree-PLRU replacement,
// flush support and saturating hit/miss counters. Lines are 256 bits wide.
module icache_assoc #(
    parameter int s_offset = 5,
    parameter int s_index  = 3,
    parameter int num_ways = 4,
    parameter int s_tag    = 32 - s_offset - s_index
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  mem_address,
    input  logic         mem_read,
    output logic [255:0] mem_rdata256,
    output logic         mem_resp,
    input  logic         flush,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
);

    localparam int num_sets  = 2 ** s_index;
    localparam int way_w     = (num_ways > 1) ? $clog2(num_ways) : 1;
    localparam int plru_lvls = $clog2(num_ways);
    localparam int plru_w    = (num_ways > 1) ? num_ways - 1 : 1;
    localparam logic [31:0] line_mask = ~((32'd1 << s_offset) - 32'd1);

    typedef logic [255:0] cacheline_t;
    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

    state_t                state_r;
    logic [num_ways-1:0]   valid_r [num_sets];
    logic [s_tag-1:0]      tag_r   [num_sets][num_ways];
    cacheline_t            data_r  [num_sets][num_ways];
    logic [plru_w-1:0]     plru_r  [num_sets];
    logic                  flush_pending_r;
    logic [31:0]           miss_addr_r;
    logic [way_w-1:0]      victim_r;
    logic [31:0]           hit_count_r;
    logic [31:0]           miss_count_r;

    logic [s_tag-1:0]      tag_s;
    logic [s_index-1:0]    index_s;
    logic [31:0]           line_addr_s;
    logic [s_tag-1:0]      miss_tag_s;
    logic [s_index-1:0]    miss_index_s;
    logic [num_ways-1:0]   hit_vec_s;
    logic                  hit_s;
    logic [way_w-1:0]      hit_way_s;
    logic [way_w-1:0]      inv_way_s;
    logic [way_w-1:0]      victim_s;
    logic                  lookup_s;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

    // Walk the heap-ordered tree; a node bit of 0 sends the victim to the lower half.
    function automatic logic [way_w-1:0] plru_victim(input logic [plru_w-1:0] bits);
        logic [way_w-1:0] way;
        int node;
        way  = '0;
        node = 0;
        for (int l = 0; l < plru_lvls; l++) begin
            for (int n = 0; n < plru_w; n++) begin
                way[plru_lvls-1-l] = (n == node) ? bits[n] : way[plru_lvls-1-l];
            end
            node = 2 * node + 1 + int'(way[plru_lvls-1-l]);
        end
        return way;
    endfunction

    // Point every node on the accessed way's path away from that way.
    function automatic logic [plru_w-1:0] plru_update(input logic [plru_w-1:0] bits,
                                                      input logic [way_w-1:0]  way);
        logic [plru_w-1:0] nb;
        int node;
        nb   = bits;
        node = 0;
        for (int l = 0; l < plru_lvls; l++) begin
            for (int n = 0; n < plru_w; n++) begin
                nb[n] = (n == node) ? ~way[plru_lvls-1-l] : nb[n];
            end
            node = 2 * node + 1 + int'(way[plru_lvls-1-l]);
        end
        return nb;
    endfunction

    assign tag_s        = mem_address[31 -: s_tag];
    assign index_s      = mem_address[s_offset +: s_index];
    assign line_addr_s  = mem_address & line_mask;
    assign miss_tag_s   = miss_addr_r[31 -: s_tag];
    assign miss_index_s = miss_addr_r[s_offset +: s_index];

    // Tag compare, hitting way and fill victim for the set addressed by mem_address.
    always_comb begin
        hit_way_s = '0;
        inv_way_s = '0;
        for (int w = 0; w < num_ways; w++) begin
            hit_vec_s[w] = valid_r[index_s][w] && (tag_r[index_s][w] == tag_s);
        end
        for (int w = num_ways - 1; w >= 0; w--) begin
            hit_way_s = hit_vec_s[w] ? way_w'(w) : hit_way_s;
            inv_way_s = valid_r[index_s][w] ? inv_way_s : way_w'(w);
        end
        hit_s    = |hit_vec_s;
        victim_s = (&valid_r[index_s]) ? plru_victim(plru_r[index_s]) : inv_way_s;
    end

    // A pending or same-cycle flush takes the IDLE cycle, so no lookup is answered then.
    assign lookup_s     = (state_r == IDLE) && !flush && !flush_pending_r && mem_read;
    assign mem_resp     = lookup_s && hit_s;
    assign mem_rdata256 = mem_resp ? data_r[index_s][hit_way_s] : 256'd0;
    assign pmem_read    = (state_r == FILL);
    assign pmem_address = (state_r == FILL) ? miss_addr_r : 32'd0;
    assign hit_count    = hit_count_r;
    assign miss_count   = miss_count_r;

    // Control FSM, valid/PLRU state, flush tracking and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r         <= IDLE;
            flush_pending_r <= 1'b0;
            miss_addr_r     <= 32'd0;
            victim_r        <= '0;
            hit_count_r     <= 32'd0;
            miss_count_r    <= 32'd0;
            for (int s = 0; s < num_sets; s++) begin
                valid_r[s] <= '0;
                plru_r[s]  <= '0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (flush || flush_pending_r) begin
                        flush_pending_r <= 1'b0;
                        for (int s = 0; s < num_sets; s++) begin
                            valid_r[s] <= '0;
                        end
                    end else if (mem_read && hit_s) begin
                        plru_r[index_s] <= plru_update(plru_r[index_s], hit_way_s);
                        hit_count_r     <= sat_inc(hit_count_r);
                    end else if (mem_read) begin
                        miss_addr_r  <= line_addr_s;
                        victim_r     <= victim_s;
                        miss_count_r <= sat_inc(miss_count_r);
                        state_r      <= FILL;
                    end
                end
                FILL: begin
                    if (flush) begin
                        flush_pending_r <= 1'b1;
                    end
                    if (pmem_resp) begin
                        valid_r[miss_index_s][victim_r] <= 1'b1;
                        plru_r[miss_index_s] <= plru_update(plru_r[miss_index_s], victim_r);
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Line and tag storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if ((state_r == FILL) && pmem_resp) begin
            data_r[miss_index_s][victim_r] <= pmem_rdata;
            tag_r[miss_index_s][victim_r]  <= miss_tag_s;
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc: a 4-way instance (index 0) and a 1-way instance (index 1).
module tb_icache_assoc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [1:0]          mem_read, flush, pmem_resp, mem_resp, pmem_read;
    logic [1:0][31:0]    mem_address, pmem_address, hit_count, miss_count;
    logic [1:0][255:0]   mem_rdata256, pmem_rdata;

    int vectors     = 0;
    int miscompares = 0;

    icache_assoc #(.s_offset(5), .s_index(3), .num_ways(4)) dut4 (
        .clk(clk), .rst(rst),
        .mem_address(mem_address[0]), .mem_read(mem_read[0]),
        .mem_rdata256(mem_rdata256[0]), .mem_resp(mem_resp[0]), .flush(flush[0]),
        .pmem_address(pmem_address[0]), .pmem_read(pmem_read[0]),
        .pmem_rdata(pmem_rdata[0]), .pmem_resp(pmem_resp[0]),
        .hit_count(hit_count[0]), .miss_count(miss_count[0])
    );

    icache_assoc #(.s_offset(5), .s_index(3), .num_ways(1)) dut1 (
        .clk(clk), .rst(rst),
        .mem_address(mem_address[1]), .mem_read(mem_read[1]),
        .mem_rdata256(mem_rdata256[1]), .mem_resp(mem_resp[1]), .flush(flush[1]),
        .pmem_address(pmem_address[1]), .pmem_read(pmem_read[1]),
        .pmem_rdata(pmem_rdata[1]), .pmem_resp(pmem_resp[1]),
        .hit_count(hit_count[1]), .miss_count(miss_count[1])
    );

    function automatic logic [255:0] line_of(input logic [31:0] a);
        return {4{a, ~a}};
    endfunction

    task automatic start_read(input logic d, input logic [31:0] a);
        mem_address[d] = a;
        mem_read[d]    = 1'b1;
        #1;
        vectors++;
        if (mem_resp[d] !== 1'b0) begin
            miscompares++;
            $display("FAIL miss_resp dut%0d addr=%h got %b want 0", d, a, mem_resp[d]);
        end
        @(negedge clk);
    endtask

    task automatic serve_fill(input logic d, input logic [31:0] a, input int lat, input int flush_at);
        int n;
        n = 0;
        #1;
        while (pmem_read[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        vectors++;
        if (n >= 20) begin
            miscompares++;
            $display("FAIL fill_timeout dut%0d addr=%h got no pmem_read want pmem_read", d, a);
        end else begin
            vectors++;
            if (pmem_address[d] !== (a & 32'hFFFF_FFE0)) begin
                miscompares++;
                $display("FAIL pmem_address dut%0d got %h want %h", d, pmem_address[d], a & 32'hFFFF_FFE0);
            end
        end
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            flush[d] = (i == flush_at);
            if (i == lat) begin
                pmem_resp[d]  = 1'b1;
                pmem_rdata[d] = line_of(a & 32'hFFFF_FFE0);
            end
            #1;
            vectors++;
            if (pmem_read[d] !== 1'b1) begin
                miscompares++;
                $display("FAIL pmem_read_held dut%0d cycle %0d got %b want 1", d, i, pmem_read[d]);
            end
        end
        @(negedge clk);
        pmem_resp[d] = 1'b0;
        flush[d]     = 1'b0;
    endtask

    task automatic check_hit(input logic d, input logic [31:0] a);
        #1;
        vectors++;
        if (mem_resp[d] !== 1'b1 || mem_rdata256[d] !== line_of(a & 32'hFFFF_FFE0)) begin
            miscompares++;
            $display("FAIL hit_data dut%0d addr=%h got resp=%b data=%h want resp=1 data=%h",
                     d, a, mem_resp[d], mem_rdata256[d], line_of(a & 32'hFFFF_FFE0));
        end
        vectors++;
        if (pmem_read[d] !== 1'b0 || pmem_address[d] !== 32'd0) begin
            miscompares++;
            $display("FAIL pmem_idle dut%0d got read=%b addr=%h want read=0 addr=0",
                     d, pmem_read[d], pmem_address[d]);
        end
        @(negedge clk);
    endtask

    task automatic read_miss(input logic d, input logic [31:0] a, input int lat);
        start_read(d, a);
        serve_fill(d, a, lat, 0);
        check_hit(d, a);
    endtask

    task automatic read_hit(input logic d, input logic [31:0] a);
        mem_address[d] = a;
        mem_read[d]    = 1'b1;
        check_hit(d, a);
    endtask

    task automatic test_reset();
        logic d;
        rst = 1'b0;
        mem_read = '0; flush = '0; pmem_resp = '0;
        mem_address = '0; pmem_rdata = '0;
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            d = 1'(k);
            vectors++;
            if (mem_resp[d] !== 1'b0 || pmem_read[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_ctl dut%0d got resp=%b pread=%b want 0 0", d, mem_resp[d], pmem_read[d]);
            end
            vectors++;
            if (pmem_address[d] !== 32'd0 || mem_rdata256[d] !== 256'd0) begin
                miscompares++;
                $display("FAIL reset_data dut%0d got paddr=%h rdata=%h want 0", d, pmem_address[d], mem_rdata256[d]);
            end
            vectors++;
            if (hit_count[d] !== 32'd0 || miss_count[d] !== 32'd0) begin
                miscompares++;
                $display("FAIL reset_counts dut%0d got hit=%0d miss=%0d want 0 0", d, hit_count[d], miss_count[d]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cold_miss();
        read_miss(1'b0, 32'h0000_0040, 4);
        #1;
        vectors++;
        if (hit_count[0] !== 32'd1 || miss_count[0] !== 32'd1) begin
            miscompares++;
            $display("FAIL cold_counts got hit=%0d miss=%0d want 1 1", hit_count[0], miss_count[0]);
        end
    endtask

    task automatic test_plru();
        logic [31:0] seq [5];
        seq[0] = 32'h000; seq[1] = 32'h100; seq[2] = 32'h200; seq[3] = 32'h300; seq[4] = 32'h000;
        for (int i = 0; i < 4; i++) read_miss(1'b0, seq[i], 2);
        for (int i = 0; i < 5; i++) read_hit(1'b0, seq[i]);
        read_miss(1'b0, 32'h400, 2);   // evicts way 2 (0x200)
        read_hit(1'b0, 32'h300);
        read_miss(1'b0, 32'h200, 3);   // evicts way 1 (0x100)
        read_hit(1'b0, 32'h000);
        read_hit(1'b0, 32'h400);
        #1;
        vectors++;
        if (hit_count[0] !== 32'd15 || miss_count[0] !== 32'd7) begin
            miscompares++;
            $display("FAIL plru_counts got hit=%0d miss=%0d want 15 7", hit_count[0], miss_count[0]);
        end
    endtask

    task automatic test_flush();
        mem_address[0] = 32'h000;
        mem_read[0]    = 1'b1;
        flush[0]       = 1'b1;
        #1;
        vectors++;
        if (mem_resp[0] !== 1'b0 || mem_rdata256[0] !== 256'd0) begin
            miscompares++;
            $display("FAIL flush_priority got resp=%b rdata=%h want 0 0", mem_resp[0], mem_rdata256[0]);
        end
        @(negedge clk);
        flush[0] = 1'b0;
        read_miss(1'b0, 32'h000, 2);
        read_miss(1'b0, 32'h040, 2);
        #1;
        vectors++;
        if (hit_count[0] !== 32'd17 || miss_count[0] !== 32'd9) begin
            miscompares++;
            $display("FAIL flush_counts got hit=%0d miss=%0d want 17 9", hit_count[0], miss_count[0]);
        end
    endtask

    task automatic test_flush_fill();
        start_read(1'b0, 32'h500);
        serve_fill(1'b0, 32'h500, 4, 2);
        #1;
        vectors++;
        if (mem_resp[0] !== 1'b0 || pmem_read[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL pending_idle got resp=%b pread=%b want 0 0", mem_resp[0], pmem_read[0]);
        end
        @(negedge clk);
        start_read(1'b0, 32'h500);
        serve_fill(1'b0, 32'h500, 2, 0);
        check_hit(1'b0, 32'h500);
        #1;
        vectors++;
        if (hit_count[0] !== 32'd18 || miss_count[0] !== 32'd11) begin
            miscompares++;
            $display("FAIL flush_fill_counts got hit=%0d miss=%0d want 18 11", hit_count[0], miss_count[0]);
        end
    endtask

    task automatic test_reset_fill();
        start_read(1'b0, 32'h600);
        #1;
        vectors++;
        if (pmem_read[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_before_reset got %b want 1", pmem_read[0]);
        end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (pmem_read[0] !== 1'b0 || pmem_address[0] !== 32'd0) begin
            miscompares++;
            $display("FAIL async_reset got pread=%b paddr=%h want 0 0", pmem_read[0], pmem_address[0]);
        end
        vectors++;
        if (hit_count[0] !== 32'd0 || miss_count[0] !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_clear got hit=%0d miss=%0d want 0 0", hit_count[0], miss_count[0]);
        end
        @(negedge clk);
        mem_read[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        read_miss(1'b0, 32'h000, 2);
        #1;
        vectors++;
        if (hit_count[0] !== 32'd1 || miss_count[0] !== 32'd1) begin
            miscompares++;
            $display("FAIL post_reset_counts got hit=%0d miss=%0d want 1 1", hit_count[0], miss_count[0]);
        end
    endtask

    task automatic test_one_way();
        logic [31:0] seq [4];
        seq[0] = 32'h000; seq[1] = 32'h100; seq[2] = 32'h000; seq[3] = 32'h100;
        for (int i = 0; i < 4; i++) begin
            start_read(1'b1, seq[i]);
            mem_read[1] = 1'b0;           // drop request mid-fill; install still happens
            serve_fill(1'b1, seq[i], 2, 0);
            #1;
            vectors++;
            if (mem_resp[1] !== 1'b0) begin
                miscompares++;
                $display("FAIL dropped_resp addr=%h got %b want 0", seq[i], mem_resp[1]);
            end
            @(negedge clk);
        end
        #1;
        vectors++;
        if (hit_count[1] !== 32'd0 || miss_count[1] !== 32'd4) begin
            miscompares++;
            $display("FAIL one_way_counts got hit=%0d miss=%0d want 0 4", hit_count[1], miss_count[1]);
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_plru();
        test_flush();
        test_flush_fill();
        test_reset_fill();
        test_one_way();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

endmodule
